// File: rtl/incubator_thermal_plant.sv
// Incubator chamber thermal model: integrates heater/cooler/fan effects on a
// prescaled tick, clamps to 0..255, drifts toward ambient when idle, and
// accepts a forced load of the temperature. Sticky fault on heater/cooler conflict.
module incubator_thermal_plant #(
  parameter int TICK_DIV  = 16,
  parameter int AMBIENT   = 25,
  parameter int RESET_T   = 25,
  parameter int HEAT_STEP = 2,
  parameter int COOL_STEP = 1,
  parameter int CRS_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             heater,
  input  logic             cooler,
  input  logic [CRS_W-1:0] crs,
  input  logic             ld_en,
  input  logic [7:0]       ld_val,
  output logic [7:0]       sensor,
  output logic [1:0]       mode,
  output logic             fault
);

  typedef enum logic [1:0] {
    DRIFT    = 2'b00,
    HEAT     = 2'b01,
    COOL     = 2'b10,
    CONFLICT = 2'b11
  } mode_e;

  localparam logic [15:0] CNT_LAST = 16'(TICK_DIV - 1);

  mode_e             mode_q, mode_d, mode_dec;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        sensor_q, sensor_d;
  logic              fault_q, fault_d;
  logic              mode_chg;
  logic signed [9:0] upd_wide;
  logic [7:0]        upd_val;

  // Decode the actuator pair into a mode: heater maps to bit 0, cooler to bit 1.
  always_comb begin
    mode_dec = mode_e'({cooler, heater});
  end

  // Candidate temperature for a tick in the current mode. The intermediate is
  // signed with headroom above 255 so both saturation directions are visible.
  always_comb begin
    upd_wide = $signed({2'b00, sensor_q});
    case (mode_q)
      HEAT: upd_wide = $signed({2'b00, sensor_q}) + $signed(10'(HEAT_STEP));
      COOL: upd_wide = $signed({2'b00, sensor_q}) - $signed(10'(COOL_STEP))
                       - $signed({{(10 - CRS_W){1'b0}}, crs});
      DRIFT: begin
        if (sensor_q > 8'(AMBIENT)) begin
          upd_wide = $signed({2'b00, sensor_q}) - 10'sd1;
        end else if (sensor_q < 8'(AMBIENT)) begin
          upd_wide = $signed({2'b00, sensor_q}) + 10'sd1;
        end
      end
      default: upd_wide = $signed({2'b00, sensor_q});
    endcase
    if (upd_wide < 10'sd0) begin
      upd_val = 8'd0;
    end else if (upd_wide > 10'sd255) begin
      upd_val = 8'd255;
    end else begin
      upd_val = upd_wide[7:0];
    end
  end

  // Next state: a load beats a mode change, which beats a tick; a mode change
  // or load restarts the prescaler so the next update is a full period away.
  always_comb begin
    mode_d   = mode_dec;
    cnt_d    = cnt_q;
    sensor_d = sensor_q;
    fault_d  = fault_q;
    mode_chg = (mode_dec != mode_q);
    if (mode_chg && (mode_dec == CONFLICT)) begin
      fault_d = 1'b1;
    end
    if (ld_en) begin
      sensor_d = ld_val;
      cnt_d    = 16'd0;
    end else if (mode_chg) begin
      cnt_d = 16'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = 16'd0;
      sensor_d = upd_val;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers; reset dominates the load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sensor_q <= 8'(RESET_T);
      mode_q   <= DRIFT;
      cnt_q    <= 16'd0;
      fault_q  <= 1'b0;
    end else begin
      sensor_q <= sensor_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
    end
  end

  assign sensor = sensor_q;
  assign mode   = mode_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_incubator_thermal_plant.sv
// Bench for the incubator thermal plant: directed scenarios with literal
// expectations, then randomized inputs, all checked every cycle against a
// behavioural model of the chamber.
module tb_incubator_thermal_plant;

  localparam int TICK = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       heater = 1'b0;
  logic       cooler = 1'b0;
  logic [3:0] crs = 4'd0;
  logic       ld_en = 1'b0;
  logic [7:0] ld_val = 8'd0;
  logic [7:0] sensor;
  logic [1:0] mode;
  logic       fault;

  int tests = 0;
  int fails = 0;

  // Model state: temperature, mode, edges since the last prescaler restart.
  int m_temp = 0;
  int m_mode = 0;
  int m_age  = 0;
  bit m_fault = 1'b0;
  bit m_valid = 1'b0;

  incubator_thermal_plant dut (
    .clk    (clk),
    .rst    (rst),
    .heater (heater),
    .cooler (cooler),
    .crs    (crs),
    .ld_en  (ld_en),
    .ld_val (ld_val),
    .sensor (sensor),
    .mode   (mode),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Effect of one thermal update, straight from the chamber rules.
  function automatic int next_temp(input int t, input int md, input int c);
    int r;
    case (md)
      1: r = t + 2;
      2: r = t - (1 + c);
      0: r = (t > 25) ? t - 1 : ((t < 25) ? t + 1 : t);
      default: r = t;
    endcase
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  // Advance the model on each rising edge using the inputs presented to it.
  always @(posedge clk) begin
    int nd;
    bit changed;
    if (rst) begin
      m_temp  = 25;
      m_mode  = 0;
      m_age   = 0;
      m_fault = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      nd = (heater && cooler) ? 3 : (heater ? 1 : (cooler ? 2 : 0));
      changed = (nd != m_mode);
      if (changed && nd == 3) m_fault = 1'b1;
      m_mode = nd;
      if (ld_en) begin
        m_temp = ld_val;
        m_age  = 0;
      end else if (changed) begin
        m_age = 0;
      end else begin
        m_age++;
        if (m_age == TICK) begin
          m_age  = 0;
          m_temp = next_temp(m_temp, m_mode, int'(crs));
        end
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_sensor", int'(sensor), m_temp);
      check("model_mode", int'(mode), m_mode);
      check("model_fault", int'(fault), int'(m_fault));
    end
  end

  task automatic pin(input string name, input int act, input int exp);
    $display("[TB] %s = %0d (want %0d)", name, act, exp);
    check(name, act, exp);
  endtask

  task automatic load(input int v);
    ld_en  = 1'b1;
    ld_val = 8'(v);
    tick(1);
    ld_en  = 1'b0;
  endtask

  initial begin
    int hold, sel;
    // Reset and idle at ambient.
    tick(3);
    rst = 1'b0;
    tick(1);
    pin("reset_sensor", int'(sensor), 25);
    pin("reset_mode", int'(mode), 0);
    pin("reset_fault", int'(fault), 0);
    tick(100);
    pin("idle_sensor", int'(sensor), 25);

    // Heating from 25: first change exactly TICK edges after mode entry.
    heater = 1'b1;
    tick(1);
    pin("heat_mode", int'(mode), 1);
    tick(TICK - 1);
    pin("heat_before_first", int'(sensor), 25);
    tick(1);
    pin("heat_first", int'(sensor), 27);
    tick(TICK * 9);
    pin("heat_ten_ticks", int'(sensor), 45);

    // Saturation at the top.
    load(250);
    tick(TICK); pin("sat_1", int'(sensor), 252);
    tick(TICK); pin("sat_2", int'(sensor), 254);
    tick(TICK); pin("sat_3", int'(sensor), 255);
    tick(TICK); pin("sat_4", int'(sensor), 255);

    // Cooling with fan speed, floored at zero.
    heater = 1'b0;
    cooler = 1'b1;
    crs    = 4'd8;
    load(10);
    pin("cool_mode", int'(mode), 2);
    tick(TICK); pin("cool_1", int'(sensor), 1);
    tick(TICK); pin("cool_2", int'(sensor), 0);
    tick(TICK); pin("cool_3", int'(sensor), 0);

    // Drift toward ambient from both sides.
    cooler = 1'b0;
    crs    = 4'd0;
    load(30);
    tick(TICK); pin("drift_down_1", int'(sensor), 29);
    tick(TICK * 4); pin("drift_down_settle", int'(sensor), 25);
    tick(TICK * 3); pin("drift_hold", int'(sensor), 25);
    load(20);
    tick(TICK * 5); pin("drift_up_settle", int'(sensor), 25);

    // Mode toggling faster than the tick keeps the temperature frozen.
    load(40);
    for (int i = 0; i < 10; i++) begin
      heater = ~heater;
      tick(10);
    end
    pin("toggle_frozen", int'(sensor), 40);

    // Conflict: sticky fault, frozen temperature, cleared only by reset.
    heater = 1'b1;
    cooler = 1'b1;
    tick(1);
    pin("conflict_mode", int'(mode), 3);
    pin("conflict_fault", int'(fault), 1);
    tick(40);
    pin("conflict_frozen", int'(sensor), 40);
    heater = 1'b0;
    cooler = 1'b0;
    tick(20);
    pin("fault_sticky", int'(fault), 1);
    rst    = 1'b1;
    ld_en  = 1'b1;
    ld_val = 8'd99;
    tick(1);
    rst    = 1'b0;
    ld_en  = 1'b0;
    pin("rst_clears_fault", int'(fault), 0);
    pin("rst_beats_load", int'(sensor), 25);

    // Randomized phase: held input patterns with sporadic loads and resets.
    for (int i = 0; i < 120; i++) begin
      hold = $urandom_range(1, 40);
      sel  = $urandom_range(0, 7);
      heater = (sel >= 3 && sel <= 4) || (sel == 7);
      cooler = (sel >= 5);
      crs    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 24) == 0) begin
          ld_en = 1'b1;
          sel = $urandom_range(0, 3);
          ld_val = (sel == 0) ? 8'($urandom_range(0, 5))
                 : (sel == 1) ? 8'($urandom_range(250, 255))
                 : 8'($urandom);
        end
        tick(1);
        ld_en = 1'b0;
      end
      $display("[TB] random burst %0d: heater=%0b cooler=%0b crs=%0d hold=%0d sensor=%0d",
               i, heater, cooler, crs, hold, sensor);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
